// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port 1024x32 data memory between the
// CPU load/store stage (requester 0) and the program/data loader (requester 1).
// Round-robin arbitration with a bounded lock, req/gnt/resp handshake, and a
// registered shared response bus carrying read data and a misalignment error.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   r{0,1}_req/we/lock           request valid, write select, keep-ownership hint
//   r{0,1}_addr/wdata            byte address and write data
//   gnt[1:0]                     one-cycle accept pulse per requester
//   resp_valid[1:0]              one-cycle response pulse per requester
//   resp_err, resp_rdata         response qualifier (misaligned) and read data
//   mem_write, mem_read          memory MemWrite / MemRead strobes
//   mem_address, mem_write_data  memory address and write data
//   mem_read_data                memory combinational read data
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_LOCK   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r1_req,
    input  logic                  r0_we,
    input  logic                  r1_we,
    input  logic                  r0_lock,
    input  logic                  r1_lock,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state;
    logic                  last_q;      // last winner; also owner of the access in flight
    logic [CNT_W-1:0]      lock_cnt;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [1:0]            req_v;
    logic [1:0]            lock_v;
    logic                  win_valid;
    logic                  win_id;
    logic [CNT_W-1:0]      cnt_next;
    logic                  aligned;
    logic                  in_access;

    assign req_v  = {r1_req, r0_req};
    assign lock_v = {r1_lock, r0_lock};

    // Round-robin pick with the last winner allowed to keep ownership while
    // it holds lock and has not exhausted its MAX_LOCK budget.
    always_comb begin
        win_valid = 1'b0;
        win_id    = 1'b0;
        cnt_next  = '0;
        if (req_v[last_q] && lock_v[last_q] && (lock_cnt < CNT_W'(MAX_LOCK))) begin
            win_valid = 1'b1;
            win_id    = last_q;
            cnt_next  = lock_cnt + CNT_W'(1);
        end else begin
            if (r0_req && r1_req) begin
                win_valid = 1'b1;
                win_id    = ~last_q;
            end else if (r0_req) begin
                win_valid = 1'b1;
                win_id    = 1'b0;
            end else if (r1_req) begin
                win_valid = 1'b1;
                win_id    = 1'b1;
            end
            // Same owner still holding lock at the cap keeps its count.
            if (win_id == last_q && lock_v[win_id]) begin
                cnt_next = lock_cnt;
            end
        end
    end

    // Memory strobes; a reset during ACCESS suppresses the write immediately.
    assign in_access      = (state == ACCESS);
    assign aligned        = (addr_q[1:0] == 2'b00);
    assign mem_write      = in_access && we_q && aligned && !reset;
    assign mem_read       = in_access && !we_q && aligned;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;

    // Handshake FSM with registered gnt/resp outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_q     <= 1'b1;
            lock_cnt   <= '0;
            gnt        <= '0;
            resp_valid <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            gnt        <= '0;
            resp_valid <= '0;
            case (state)
                IDLE, RESP: begin
                    if (win_valid) begin
                        last_q   <= win_id;
                        lock_cnt <= cnt_next;
                        we_q     <= win_id ? r1_we    : r0_we;
                        addr_q   <= win_id ? r1_addr  : r0_addr;
                        wdata_q  <= win_id ? r1_wdata : r0_wdata;
                        gnt      <= win_id ? 2'b10 : 2'b01;
                        state    <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    resp_rdata <= mem_read ? mem_read_data : '0;
                    resp_err   <= !aligned;
                    resp_valid <= last_q ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        r0_req, r1_req, r0_we, r1_we, r0_lock, r1_lock;
    logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
    logic [1:0]  gnt, resp_valid;
    logic        resp_err, mem_write, mem_read;
    logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;

    logic [31:0] mem [1024];

    always #5 clock = ~clock;

    data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_LOCK(4)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_lock(r0_lock), .r1_lock(r1_lock),
        .r0_addr(r0_addr), .r1_addr(r1_addr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .gnt(gnt), .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    // Memory model: combinational gated read, write on rising edge.
    assign mem_read_data = mem_read ? mem[mem_address[11:2]] : 32'h0;
    always @(posedge clock) begin
        if (mem_write) begin
            mem[mem_address[11:2]] <= mem_write_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0; r0_lock = 0; r1_lock = 0;
        r0_addr = 0; r1_addr = 0; r0_wdata = 0; r1_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Issue one access for requester id and wait (bounded) for gnt and resp.
    task automatic access(input int id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output logic ok);
        ok = 0; rdata = 0; err = 0;
        if (id == 0) begin r0_req = 1; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
        else         begin r1_req = 1; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt[id]) begin ok = 1; break; end
        end
        if (id == 0) r0_req = 0; else r1_req = 0;
        if (ok) begin
            tick();
            ok    = resp_valid[id];
            rdata = resp_rdata;
            err   = resp_err;
        end
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (gnt !== 2'b00)        begin n_fail++; $display("FAIL reset_gnt got %b exp 00", gnt); end
        n_tests++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 00", resp_valid); end
        n_tests++; if (resp_err !== 1'b0)    begin n_fail++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
        n_tests++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_resp_rdata got %h exp 0", resp_rdata); end
        n_tests++; if (mem_write !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_write got %b exp 0", mem_write); end
        n_tests++; if (mem_read !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_read got %b exp 0", mem_read); end
    endtask

    task automatic test_single_read();
        logic [31:0] rd; logic er, ok;
        access(1, 1'b1, 32'h40, 32'hDEADBEEF, rd, er, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL preload_handshake got %b exp 1", ok); end
        r0_req = 1; r0_we = 0; r0_addr = 32'h40;
        tick();
        n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt got %b exp 01", gnt); end
        r0_req = 0;
        tick();
        n_tests++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL single_resp_valid got %b exp 01", resp_valid); end
        n_tests++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata got %h exp deadbeef", resp_rdata); end
        n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL single_err got %b exp 0", resp_err); end
        tick();
    endtask

    task automatic test_conflict();
        logic [1:0] exp;
        do_reset();
        r0_req = 1; r0_addr = 32'h100; r1_req = 1; r1_addr = 32'h104;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = (i % 2 != 0) ? 2'b00 : (((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
            n_tests++;
            if (gnt !== exp) begin n_fail++; $display("FAIL conflict_gnt cycle %0d got %b exp %b", i, gnt, exp); end
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_lock();
        logic [31:0] rd; logic er, ok;
        logic [1:0] exp;
        do_reset();
        access(0, 1'b0, 32'h40, 32'h0, rd, er, ok);   // makes requester 0 the last winner
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL lock_setup_handshake got %b exp 1", ok); end
        r0_req = 1; r0_addr = 32'h40; r1_req = 1; r1_addr = 32'h40; r1_lock = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = (i % 2 != 0) ? 2'b00 : ((i < 10) ? 2'b10 : 2'b01);
            n_tests++;
            if (gnt !== exp) begin n_fail++; $display("FAIL lock_gnt cycle %0d got %b exp %b", i, gnt, exp); end
            if (i == 10) begin
                n_tests++;
                if (dut.lock_cnt !== 4'd0) begin n_fail++; $display("FAIL lock_cnt_cleared got %0d exp 0", dut.lock_cnt); end
            end
        end
        idle_inputs();
        tick(); tick();
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er, ok;
        int wr0;
        wr0 = wr_count;
        access(0, 1'b1, 32'h42, 32'h12345678, rd, er, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL misaligned_handshake got %b exp 1", ok); end
        n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_err got %b exp 1", er); end
        n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_rdata got %h exp 0", rd); end
        n_tests++; if (wr_count !== wr0) begin n_fail++; $display("FAIL misaligned_write_count got %0d exp %0d", wr_count, wr0); end
        access(0, 1'b0, 32'h40, 32'h0, rd, er, ok);
        n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL misaligned_readback got %h exp deadbeef", rd); end
        n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL aligned_err got %b exp 0", er); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, ok;
        access(0, 1'b1, 32'h10, 32'h01234567, rd, er, ok);
        access(0, 1'b0, 32'h10, 32'h0, rd, er, ok);   // leaves nonzero resp_rdata
        r0_req = 1; r0_we = 1; r0_addr = 32'h10; r0_wdata = 32'hAAAA5555;
        tick();
        n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL midreset_gnt got %b exp 01", gnt); end
        reset = 1;
        #1;
        n_tests++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL midreset_mem_write got %b exp 0", mem_write); end
        tick();
        reset = 0;
        idle_inputs();
        n_tests++;
        if (gnt !== 2'b00 || resp_valid !== 2'b00 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
            mem_write !== 1'b0 || mem_read !== 1'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs got gnt=%b rv=%b err=%b rd=%h mw=%b mr=%b ma=%h exp all zero",
                     gnt, resp_valid, resp_err, resp_rdata, mem_write, mem_read, mem_address);
        end
        tick();
        n_tests++; if (resp_valid !== 2'b00) begin n_fail++; $display("FAIL midreset_no_resp got %b exp 00", resp_valid); end
        access(0, 1'b0, 32'h10, 32'h0, rd, er, ok);
        n_tests++; if (rd !== 32'h01234567) begin n_fail++; $display("FAIL midreset_readback got %h exp 01234567", rd); end
    endtask

    task automatic test_back_to_back();
        r0_req = 1; r0_we = 1; r0_addr = 32'h0; r0_wdata = 32'hCAFEF00D;
        tick();
        n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_gnt1 got %b exp 01", gnt); end
        r0_we = 0; r0_wdata = 32'h0;
        tick();
        n_tests++; if (resp_valid !== 2'b01 || gnt !== 2'b00) begin n_fail++; $display("FAIL b2b_resp1 got rv=%b gnt=%b exp 01/00", resp_valid, gnt); end
        tick();
        n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL b2b_gnt2 got %b exp 01", gnt); end
        r0_req = 0;
        tick();
        n_tests++; if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL b2b_resp2 got %b exp 01", resp_valid); end
        n_tests++; if (resp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_rdata got %h exp cafef00d", resp_rdata); end
        n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err got %b exp 0", resp_err); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_conflict();
        test_lock();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data memory (1024 x 32, combinational read, write on clock rising edge, gated by MemWrite/MemRead) between two requesters.
- Requester 0 is the CPU load/store stage; requester 1 is the program/data loader (DMA-style).
- Arbitration is round-robin with an optional bounded lock, and each requester uses a req/gnt/resp handshake.
- Read data and a misalignment error are returned on a registered, shared response bus.

Parameters:
- ADDR_WIDTH, 32, width of requester and memory addresses
- DATA_WIDTH, 32, word width
- MAX_LOCK, 4, maximum consecutive accesses one locked requester may win while the other waits (range 1..15)

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- r0_req, r1_req  in  1 each  request valid; held high until gnt for that requester is seen
- r0_we, r1_we  in  1 each  1 = write, 0 = read
- r0_lock, r1_lock  in  1 each  request to keep ownership for the next access
- r0_addr, r1_addr  in  ADDR_WIDTH each  byte address
- r0_wdata, r1_wdata  in  DATA_WIDTH each  write data
- gnt  out  2  one-cycle pulse; bit i means request i has been accepted
- resp_valid  out  2  one-cycle pulse; bit i means the response for requester i is on the bus
- resp_err  out  1  qualifies resp_valid; 1 = misaligned access, not performed
- resp_rdata  out  DATA_WIDTH  read data (0 for writes and for errors)
- mem_write  out  1  drives the memory MemWrite input
- mem_read  out  1  drives the memory MemRead input
- mem_address  out  ADDR_WIDTH  drives the memory address input
- mem_write_data  out  DATA_WIDTH  drives the memory write_data input
- mem_read_data  in  DATA_WIDTH  memory read_data

Behaviour:
- States:
  - IDLE: no access pending.
  - ACCESS: memory is driven for exactly one cycle.
  - RESP: the response is presented.
- Reset (synchronous):
  - state returns to IDLE;
  - last winner pointer is set to 1, so requester 0 wins the first conflict;
  - lock counter is cleared;
  - gnt, resp_valid, resp_err, resp_rdata, mem_read and mem_write are all 0.
- Arbitration is evaluated in IDLE and in RESP, which allows back-to-back accesses.
  - With one request, that requester wins.
  - With both requests, the requester that is not the last winner wins.
  - Lock exception: if the last winner's lock and req are both high and lock_cnt < MAX_LOCK, the last winner wins again and lock_cnt increments.
  - Any switch of owner, and any win with lock low, clears lock_cnt to 0.
- On a win:
  - the winner's we, addr and wdata are latched into internal registers;
  - the winner is recorded as last winner;
  - the next state is ACCESS.
  - With no request: IDLE stays IDLE, and RESP goes to IDLE.
- In the ACCESS cycle:
  - gnt[winner] = 1;
  - mem_address and mem_write_data come from the latched registers;
  - mem_write = latched we and aligned;
  - mem_read = (not latched we) and aligned, where aligned = (latched addr[1:0] == 0);
  - mem_read and mem_write are 0 in every other state.
  - resp_rdata is loaded from mem_read_data when mem_read is high, and with 0 otherwise.
  - resp_err is loaded with (not aligned).
  - The next state is RESP.
- In the RESP cycle: resp_valid[winner] = 1; resp_rdata and resp_err hold until the next ACCESS.
- Latency:
  - req sampled high at edge N → gnt is high in the cycle after edge N.
  - The write commits at edge N+1.
  - resp_valid is high in the cycle after edge N+1.
  - Sustained throughput is one access per 2 cycles.
- The requester may drop or change req and operands after the cycle in which gnt is high; later changes do not affect the access in flight.
- A misaligned access performs no memory write, returns rdata = 0 and err = 1, and still counts for arbitration and lock.
- mem_write is additionally gated by not reset. If reset is high during ACCESS, no write commits, and no gnt or resp is produced after reset.
- A req that drops before gnt is legal: if it drops while in IDLE before the sampling edge, no access occurs.

Test Plan:
- Single read: after reset, preload word 0x40 with 0xDEADBEEF via r1 write; then r0_req, read, addr 0x40 → gnt=01 one cycle later, resp_valid=01 the following cycle, resp_rdata=0xDEADBEEF, resp_err=0.
- Conflict: r0 and r1 request continuously with lock=0 → grant order 0,1,0,1; one gnt every 2 cycles; never both gnt bits high.
- Lock bound: r1_lock=1 with MAX_LOCK=4, r0 and r1 both requesting → r1 wins 5 consecutive times (1 initial + 4 locked), then r0 wins, and lock_cnt reads 0.
- Misaligned: r0 write, addr 0x42, data 0x12345678 → mem_write stays 0; resp_err=1, resp_rdata=0; a later aligned read of 0x40 returns the old value.
- Reset mid-access: reset high during the ACCESS cycle of an r0 write of 0xAAAA5555 to 0x10 → no write; following read of 0x10 returns the prior value; all outputs 0 in the cycle after reset.
- Back-to-back: r0 writes 0x0 then reads 0x0 with req held high → second gnt 2 cycles after the first; read returns the newly written value.
